cnn_layer_accel_layer_engine_dispatcher: RTL and testbench
==========================================================

CNN_LAYER_ACCEL_LAYER_ENGINE_DISPATCHER -- requirements
Module: cnn_layer_accel_layer_engine_dispatcher

Interface
REQ-001 Parameter C_PACKET_WIDTH, default 66, packet width; SHALL be fixed at 66.
REQ-002 Parameter C_TIMEOUT_CYCLES, default 65535, completion-wait limit in cycles; valid range 1 to 2^16-1.
REQ-003 Port clk, input, 1 bit: the only clock.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Ports job_valid (input, 1) and job_ready (output, 1): job request handshake.
REQ-006 Port job_tag, input, 8 bits; job_opcode, input, 8 bits; job_cfg0 and job_cfg1, input, 64 bits each: job fields.
REQ-007 Ports job_done (output, 1, one-cycle pulse), job_status (output, 8) and job_error (output, 1): job result.
REQ-008 Ports disp_output_valid (output, 1), disp_output_accept (input, 1) and disp_output_data (output, C_PACKET_WIDTH): packets sent to the layer engine controller.
REQ-009 Ports disp_input_valid (input, 1), disp_input_accept (output, 1) and disp_input_data (input, C_PACKET_WIDTH): completion packets from the controller.

Function
REQ-010 A transfer SHALL occur on any cycle where valid and accept are both high.
REQ-011 The state machine SHALL be one-hot, 6 bits: ST_IDLE, ST_SEND_HEADER, ST_SEND_CFG0, ST_SEND_CFG1, ST_WAIT_COMPLETION, ST_REPORT.
REQ-012 job_ready SHALL be 1 only in ST_IDLE; on a job transfer, the block SHALL register all job fields and move to ST_SEND_HEADER.
REQ-013 disp_output_valid SHALL assert in the cycle after the job transfer (latency 1).
REQ-014 Header packet format: {2'b01, 40'd0, opcode, tag, 8'd2}.
REQ-015 CFG0 packet format: {2'b00, cfg0}. CFG1 packet format: {2'b10, cfg1}, where 2'b10 marks the last packet.
REQ-016 Each SEND state SHALL hold disp_output_valid high and disp_output_data stable until accepted, then advance: HEADER to CFG0, CFG0 to CFG1, CFG1 to WAIT_COMPLETION.
REQ-017 Back-to-back accepts SHALL give 3 packets in 3 consecutive cycles; disp_output_valid SHALL be 0 outside the SEND states.
REQ-018 disp_input_accept SHALL be 1 only in ST_WAIT_COMPLETION; packets offered in any other state SHALL stay un-accepted (held off).
REQ-019 On a completion transfer, the block SHALL capture status = data[7:0].
REQ-020 The block SHALL set error = 1 if data[65:64] != 2'b11 or data[15:8] != registered tag, then go to ST_REPORT.
REQ-021 In ST_REPORT, job_done SHALL be 1 for exactly one cycle, with job_status and job_error valid in that cycle; the next state SHALL be ST_IDLE.
REQ-022 job_status and job_error SHALL hold their values until the next ST_REPORT.
REQ-023 A job_valid held high during ST_REPORT SHALL be accepted no earlier than the following cycle (ST_IDLE).
REQ-024 A completion offered while in ST_SEND_CFG1 SHALL NOT be consumed until ST_WAIT_COMPLETION is entered.

Reset
REQ-025 rst SHALL force ST_IDLE and clear the timeout counter and registered fields.
REQ-026 Output values under rst: job_ready=1 in the following cycle; job_done=0, job_status=0, job_error=0, disp_output_valid=0, disp_output_data=0, disp_input_accept=0.
REQ-027 rst asserted mid-packet or mid-wait SHALL abort the job with no job_done pulse; the sender SHALL drop valid without completing the transfer.

Configuration
REQ-028 Macro CNN_LAYER_ACCEL_DISP_TIMEOUT_EN, when defined, SHALL add a 16-bit counter with this behaviour:
- clears on entry to ST_WAIT_COMPLETION and increments each cycle there;
- on reaching C_TIMEOUT_CYCLES with no completion, go to ST_REPORT with job_status=8'hFF and job_error=1;
- a completion arriving on the same cycle as expiry takes priority over the timeout.
REQ-029 Without the macro, the block SHALL have no counter and SHALL wait indefinitely in ST_WAIT_COMPLETION.

Verification
REQ-030 Basic job: tag=8'h5A, opcode=8'h03, cfg0=64'h1111, cfg1=64'h2222, accept always 1 -> packets 66'h1_0000_0000_0003_5A02, 66'h0_..._1111, 66'h2_..._2222 on 3 consecutive cycles.
- Then completion {2'b11, 48'd0, 8'h5A, 8'h00} -> job_done pulse, status 8'h00, error 0.
REQ-031 Backpressure: disp_output_accept low for 4 cycles on each packet -> data stable while stalled, each packet sent exactly once, in order.
REQ-032 Tag mismatch: completion tag 8'h5B for job tag 8'h5A -> job_done with error=1 and status taken from data[7:0].
REQ-033 Early completion: disp_input_valid high from job start -> not accepted until after the CFG1 transfer, then consumed in 1 cycle.
REQ-034 Reset mid-operation: rst during ST_SEND_CFG0 -> disp_output_valid=0 next cycle, no job_done, next job runs normally.
REQ-035 Timeout: with CNN_LAYER_ACCEL_DISP_TIMEOUT_EN defined and C_TIMEOUT_CYCLES=16, no completion -> job_done 17 cycles after the CFG1 transfer, status 8'hFF, error=1.
- Without the macro, the block SHALL still be in ST_WAIT_COMPLETION after 1000 cycles.

Source files
------------

// File: rtl/cnn_layer_accel_layer_engine_dispatcher.sv
// cnn_layer_accel_layer_engine_dispatcher: turns a job into header/cfg0/cfg1 packets and reports its completion.
// Define CNN_LAYER_ACCEL_DISP_TIMEOUT_EN to bound the completion wait by C_TIMEOUT_CYCLES.
module cnn_layer_accel_layer_engine_dispatcher #(
  parameter int C_PACKET_WIDTH   = 66,
  parameter int C_TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [7:0]                job_tag,
  input  logic [7:0]                job_opcode,
  input  logic [63:0]               job_cfg0,
  input  logic [63:0]               job_cfg1,
  output logic                      job_done,
  output logic [7:0]                job_status,
  output logic                      job_error,
  output logic                      disp_output_valid,
  input  logic                      disp_output_accept,
  output logic [C_PACKET_WIDTH-1:0] disp_output_data,
  input  logic                      disp_input_valid,
  output logic                      disp_input_accept,
  input  logic [C_PACKET_WIDTH-1:0] disp_input_data
);
  typedef enum logic [5:0] {
    ST_IDLE            = 6'b000001,
    ST_SEND_HEADER     = 6'b000010,
    ST_SEND_CFG0       = 6'b000100,
    ST_SEND_CFG1       = 6'b001000,
    ST_WAIT_COMPLETION = 6'b010000,
    ST_REPORT          = 6'b100000
  } state_t;
  state_t      state_q;
  logic [7:0]  tag_q;
  logic [7:0]  op_q;
  logic [63:0] cfg0_q;
  logic [63:0] cfg1_q;
  logic [7:0]  status_q;
  logic        error_q;
  logic        unused_bits;
`ifdef CNN_LAYER_ACCEL_DISP_TIMEOUT_EN
  logic [15:0] cnt_q;
`endif
  assign unused_bits       = ^{disp_input_data[63:16], 16'(C_TIMEOUT_CYCLES)};
  assign job_ready         = state_q == ST_IDLE;
  assign job_done          = state_q == ST_REPORT;
  assign job_status        = status_q;
  assign job_error         = error_q;
  assign disp_input_accept = state_q == ST_WAIT_COMPLETION;
  assign disp_output_valid = state_q inside {ST_SEND_HEADER, ST_SEND_CFG0, ST_SEND_CFG1};
  assign disp_output_data  = (state_q == ST_SEND_HEADER) ? {2'b01, 40'd0, op_q, tag_q, 8'd2} :
                             (state_q == ST_SEND_CFG0)   ? {2'b00, cfg0_q} :
                             (state_q == ST_SEND_CFG1)   ? {2'b10, cfg1_q} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tag_q    <= '0;
      op_q     <= '0;
      cfg0_q   <= '0;
      cfg1_q   <= '0;
      status_q <= '0;
      error_q  <= 1'b0;
`ifdef CNN_LAYER_ACCEL_DISP_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: if (job_valid) begin
          tag_q   <= job_tag;
          op_q    <= job_opcode;
          cfg0_q  <= job_cfg0;
          cfg1_q  <= job_cfg1;
          state_q <= ST_SEND_HEADER;
        end
        ST_SEND_HEADER: if (disp_output_accept) state_q <= ST_SEND_CFG0;
        ST_SEND_CFG0:   if (disp_output_accept) state_q <= ST_SEND_CFG1;
        ST_SEND_CFG1: if (disp_output_accept) begin
          state_q <= ST_WAIT_COMPLETION;
`ifdef CNN_LAYER_ACCEL_DISP_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        // a completion in the expiry cycle wins over the timeout
        ST_WAIT_COMPLETION: if (disp_input_valid) begin
          status_q <= disp_input_data[7:0];
          error_q  <= (disp_input_data[65:64] != 2'b11) || (disp_input_data[15:8] != tag_q);
          state_q  <= ST_REPORT;
        end
`ifdef CNN_LAYER_ACCEL_DISP_TIMEOUT_EN
        else if (cnt_q == 16'(C_TIMEOUT_CYCLES - 1)) begin
          status_q <= 8'hFF;
          error_q  <= 1'b1;
          state_q  <= ST_REPORT;
        end else cnt_q <= cnt_q + 16'd1;
`endif
        ST_REPORT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_layer_accel_layer_engine_dispatcher.sv
// tb_cnn_layer_accel_layer_engine_dispatcher: vector table, hand sequences and random jobs against a packet-level model.
module tb_cnn_layer_accel_layer_engine_dispatcher;
  logic        clk, rst;
  logic        job_valid, job_ready, job_done, job_error;
  logic [7:0]  job_tag, job_opcode, job_status;
  logic [63:0] job_cfg0, job_cfg1;
  logic        disp_output_valid, disp_output_accept, disp_input_valid, disp_input_accept;
  logic [65:0] disp_output_data, disp_input_data;
  int checks = 0;
  int errors = 0;
  cnn_layer_accel_layer_engine_dispatcher #(.C_PACKET_WIDTH(66), .C_TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_tag(job_tag), .job_opcode(job_opcode), .job_cfg0(job_cfg0), .job_cfg1(job_cfg1),
    .job_done(job_done), .job_status(job_status), .job_error(job_error),
    .disp_output_valid(disp_output_valid), .disp_output_accept(disp_output_accept),
    .disp_output_data(disp_output_data),
    .disp_input_valid(disp_input_valid), .disp_input_accept(disp_input_accept),
    .disp_input_data(disp_input_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0]  tag, op;
    logic [63:0] c0, c1;
    int          stall;
    bit          early;
    logic [65:0] comp;
    int          dly;
    logic [7:0]  st;
    bit          er;
  } vec_t;
  vec_t tv[6];
  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    job_valid = 1'b0;
    disp_output_accept = 1'b0;
    disp_input_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  // entered and left at a negedge with the DUT idle; dly < 0 means no completion is ever offered
  task automatic run_job(input logic [7:0] tag, input logic [7:0] op, input logic [63:0] c0,
                         input logic [63:0] c1, input int stall, input bit early,
                         input logic [65:0] comp, input int dly, input logic [7:0] est,
                         input bit eer, input bit hold_next);
    logic [65:0] pk[3];
    int n = 0;
    int wc = 0;
    bit seen_done = 0;
    pk[0] = {2'b01, 40'd0, op, tag, 8'd2};
    pk[1] = {2'b00, c0};
    pk[2] = {2'b10, c1};
    chkb("job_ready_idle", job_ready, 1'b1);
    job_valid = 1'b1;
    job_tag = tag;
    job_opcode = op;
    job_cfg0 = c0;
    job_cfg1 = c1;
    disp_input_valid = early;
    disp_input_data = comp;
    @(negedge clk);
    job_valid = 1'b0;
    while (n < 3) begin
      chkb("out_valid_send", disp_output_valid, 1'b1);
      chk("out_data", disp_output_data, pk[n]);
      chkb("in_accept_held_off", disp_input_accept, 1'b0);
      chkb("job_ready_busy", job_ready, 1'b0);
      if (wc < stall) begin
        disp_output_accept = 1'b0;
        wc++;
      end else begin
        disp_output_accept = 1'b1;
        n++;
        wc = 0;
      end
      @(negedge clk);
    end
    disp_output_accept = 1'b0;
    chkb("out_valid_after_cfg1", disp_output_valid, 1'b0);
    chkb("in_accept_wait", disp_input_accept, 1'b1);
    if (dly < 0) begin
`ifdef CNN_LAYER_ACCEL_DISP_TIMEOUT_EN
      repeat (16) begin
        chkb("no_done_before_timeout", job_done, 1'b0);
        @(negedge clk);
      end
      chkb("timeout_done", job_done, 1'b1);
      chk("timeout_status", 66'(job_status), 66'(8'hFF));
      chkb("timeout_error", job_error, 1'b1);
      @(negedge clk);
      chkb("timeout_idle", job_ready, 1'b1);
`else
      repeat (1000) begin
        seen_done |= job_done;
        @(negedge clk);
      end
      chkb("no_timeout_done", seen_done, 1'b0);
      chkb("still_waiting", disp_input_accept, 1'b1);
      do_reset();
`endif
    end else begin
      repeat (early ? 0 : dly) begin
        chkb("no_done_waiting", job_done, 1'b0);
        chkb("in_accept_waiting", disp_input_accept, 1'b1);
        @(negedge clk);
      end
      disp_input_valid = 1'b1;
      disp_input_data = comp;
      @(negedge clk);
      disp_input_valid = 1'b0;
      chkb("job_done_pulse", job_done, 1'b1);
      chk("job_status", 66'(job_status), 66'(est));
      chkb("job_error", job_error, eer);
      chkb("job_ready_report", job_ready, 1'b0);
      chkb("in_accept_report", disp_input_accept, 1'b0);
      if (hold_next) job_valid = 1'b1;
      @(negedge clk);
      chkb("job_done_one_cycle", job_done, 1'b0);
      chkb("job_ready_after", job_ready, 1'b1);
      chk("status_hold", 66'(job_status), 66'(est));
      chkb("error_hold", job_error, eer);
      if (hold_next) begin
        chkb("held_job_not_in_report", disp_output_valid, 1'b0);
        @(negedge clk);
        job_valid = 1'b0;
        chkb("held_job_taken", disp_output_valid, 1'b1);
        chk("held_job_header", disp_output_data, pk[0]);
        do_reset();
      end
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0]  rt, ro, ctag;
    logic [63:0] r0, r1;
    logic [1:0]  hi;
    logic [65:0] rc;
    bit          re;
    tv[0] = '{8'h5A, 8'h03, 64'h1111, 64'h2222, 0, 0, {2'b11, 48'd0, 8'h5A, 8'h00}, 2, 8'h00, 0};
    tv[1] = '{8'h11, 8'h22, 64'hDEADBEEF_01234567, 64'h89ABCDEF_76543210, 4, 0,
              {2'b11, 48'd0, 8'h11, 8'h3C}, 1, 8'h3C, 0};
    tv[2] = '{8'h5A, 8'h03, 64'h1111, 64'h2222, 0, 0, {2'b11, 48'd0, 8'h5B, 8'h7E}, 0, 8'h7E, 1};
    tv[3] = '{8'hA5, 8'h07, 64'h0F0F, 64'hF0F0, 0, 1, {2'b11, 48'd0, 8'hA5, 8'h42}, 0, 8'h42, 0};
    tv[4] = '{8'h33, 8'h44, 64'h5555, 64'hAAAA, 1, 0, {2'b10, 48'd0, 8'h33, 8'h01}, 3, 8'h01, 1};
    tv[5] = '{8'hFF, 8'hFF, '1, '1, 0, 0, {2'b11, 48'hFFFF_FFFF_FFFF, 8'hFF, 8'hFF}, 0, 8'hFF, 0};
    rst = 1'b1;
    job_valid = 1'b0;
    job_tag = '0;
    job_opcode = '0;
    job_cfg0 = '0;
    job_cfg1 = '0;
    disp_output_accept = 1'b0;
    disp_input_valid = 1'b1;
    disp_input_data = '1;
    repeat (2) @(negedge clk);
    chkb("rst_job_ready", job_ready, 1'b1);
    chkb("rst_job_done", job_done, 1'b0);
    chk("rst_job_status", 66'(job_status), 66'd0);
    chkb("rst_job_error", job_error, 1'b0);
    chkb("rst_out_valid", disp_output_valid, 1'b0);
    chk("rst_out_data", disp_output_data, 66'd0);
    chkb("rst_in_accept", disp_input_accept, 1'b0);
    rst = 1'b0;
    disp_input_valid = 1'b0;
    @(negedge clk);
    chkb("idle_in_accept", disp_input_accept, 1'b0);
    foreach (tv[i])
      run_job(tv[i].tag, tv[i].op, tv[i].c0, tv[i].c1, tv[i].stall, tv[i].early,
              tv[i].comp, tv[i].dly, tv[i].st, tv[i].er, 1'b0);
    job_valid = 1'b1;
    job_tag = 8'h77;
    job_opcode = 8'h01;
    job_cfg0 = 64'hC0;
    job_cfg1 = 64'hC1;
    @(negedge clk);
    job_valid = 1'b0;
    chk("abort_header", disp_output_data, {2'b01, 40'd0, 8'h01, 8'h77, 8'd2});
    disp_output_accept = 1'b1;
    @(negedge clk);
    chk("abort_cfg0", disp_output_data, {2'b00, 64'hC0});
    disp_output_accept = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chkb("abort_out_valid", disp_output_valid, 1'b0);
    chk("abort_out_data", disp_output_data, 66'd0);
    chkb("abort_job_ready", job_ready, 1'b1);
    chk("abort_status_clr", 66'(job_status), 66'd0);
    repeat (3) begin
      chkb("abort_no_done", job_done, 1'b0);
      @(negedge clk);
    end
    run_job(tv[0].tag, tv[0].op, tv[0].c0, tv[0].c1, 0, 0, tv[0].comp, 0, 8'h00, 0, 1'b0);
    run_job(8'h12, 8'h34, 64'h99, 64'h88, 0, 0, {2'b11, 48'd0, 8'h12, 8'h05}, 0, 8'h05, 0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      rt = 8'($urandom);
      ro = 8'($urandom);
      r0 = {$urandom(), $urandom()};
      r1 = {$urandom(), $urandom()};
      hi = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      ctag = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rt;
      rc = {hi, 48'({$urandom(), $urandom()}), ctag, 8'($urandom)};
      re = (rc[65:64] != 2'b11) || (rc[15:8] != rt);
      run_job(rt, ro, r0, r1, $urandom_range(0, 3), 1'($urandom), rc, $urandom_range(0, 5),
              rc[7:0], re, 1'b0);
    end
    run_job(8'h66, 8'h09, 64'h1, 64'h2, 0, 0, '0, -1, 8'hFF, 1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
